// File: rtl/wb_pkg.sv
// Shared encodings for the writeback stage: result-select and load-size codes
// plus the bit positions of the packed WBControl field.
package wb_pkg;

   localparam logic [1:0] WB_SEL_ALU  = 2'b00;
   localparam logic [1:0] WB_SEL_MEM  = 2'b01;
   localparam logic [1:0] WB_SEL_LINK = 2'b10;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;

   localparam int WBC_SEL_HI   = 5;
   localparam int WBC_SEL_LO   = 4;
   localparam int WBC_SIZE_HI  = 3;
   localparam int WBC_SIZE_LO  = 2;
   localparam int WBC_SIGNED   = 1;
   localparam int WBC_REGWRITE = 0;

endpackage

// File: rtl/wb_load_align.sv
// Extracts a byte/half/word from the raw memory word, extends it to DATA_W and
// flags addresses that are not aligned to the access size.
module wb_load_align
   import wb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter bit BIG_ENDIAN = 1'b0,
   localparam int LANE_AW   = $clog2(DATA_W / 8)
) (
   input  logic [DATA_W-1:0]  raw_data,
   input  logic [LANE_AW-1:0] addr_lo,
   input  logic [1:0]         size,
   input  logic               load_signed,
   output logic [DATA_W-1:0]  aligned_data,
   output logic               misalign
);

   localparam int NUM_BYTES = DATA_W / 8;
   localparam int NUM_HALVES = DATA_W / 16;

   logic [LANE_AW-1:0] byte_lane;
   logic [LANE_AW-2:0] half_lane;
   logic [7:0]         byte_val;
   logic [15:0]        half_val;

   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      // Lane count is a power of two, so (N-1-k) is simply the bitwise inverse of k.
      byte_lane = BIG_ENDIAN ? ~addr_lo : addr_lo;
      half_lane = BIG_ENDIAN ? ~addr_lo[LANE_AW-1:1] : addr_lo[LANE_AW-1:1];
      byte_val  = '0;
      half_val  = '0;
      for (int i = 0; i < NUM_BYTES; i++) begin
         if (byte_lane == i[LANE_AW-1:0]) byte_val = raw_data[i*8 +: 8];
      end
      for (int i = 0; i < NUM_HALVES; i++) begin
         if (half_lane == i[LANE_AW-2:0]) half_val = raw_data[i*16 +: 16];
      end

      case (size)
         SZ_BYTE: begin
            aligned_data = {{(DATA_W-8){load_signed & byte_val[7]}}, byte_val};
            misalign     = 1'b0;
         end
         SZ_HALF: begin
            aligned_data = {{(DATA_W-16){load_signed & half_val[15]}}, half_val};
            misalign     = addr_lo[0];
         end
         default: begin
            aligned_data = raw_data;
            misalign     = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/wb_stage_p.sv
// MEM/WB pipeline register with result mux, register-file write qualification
// and a retired-instruction counter.
module wb_stage_p
   import wb_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int REG_AW     = 5,
   parameter int CNT_W      = 32,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Stall_In,
   input  logic              Flush_In,
   input  logic              Valid_In,
   input  logic [5:0]        WBControl_In,
   input  logic [DATA_W-1:0] Address_In,
   input  logic [DATA_W-1:0] Data_In,
   input  logic [DATA_W-1:0] Link_In,
   input  logic [REG_AW-1:0] WriteReg_In,
   output logic [DATA_W-1:0] Data_Out,
   output logic [REG_AW-1:0] WriteReg_Out,
   output logic              RegWrite_Out,
   output logic              Valid_Out,
   output logic              Misalign_Out,
   output logic [CNT_W-1:0]  Retired_Out
);

   localparam int LANE_AW = $clog2(DATA_W / 8);

   logic [1:0]        sel;
   logic [DATA_W-1:0] load_data;
   logic              size_misalign;
   logic              misalign;
   logic [DATA_W-1:0] result;
   logic              reg_write;

   wb_load_align #(
      .DATA_W     (DATA_W),
      .BIG_ENDIAN (BIG_ENDIAN)
   ) u_align (
      .raw_data     (Data_In),
      .addr_lo      (Address_In[LANE_AW-1:0]),
      .size         (WBControl_In[WBC_SIZE_HI:WBC_SIZE_LO]),
      .load_signed  (WBControl_In[WBC_SIGNED]),
      .aligned_data (load_data),
      .misalign     (size_misalign)
   );

   always_comb begin
      sel      = WBControl_In[WBC_SEL_HI:WBC_SEL_LO];
      misalign = (sel == WB_SEL_MEM) & size_misalign;
      case (sel)
         WB_SEL_MEM:  result = load_data;
         WB_SEL_LINK: result = Link_In;
         default:     result = Address_In;
      endcase
      reg_write = Valid_In & WBControl_In[WBC_REGWRITE] & (WriteReg_In != '0) & ~misalign;
   end

   // Reset beats flush, flush beats stall; a flush keeps the data path so only
   // the qualifying flags drop.
   always_ff @(posedge Clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!Rst_n) begin
         Data_Out     <= '0;
         WriteReg_Out <= '0;
         RegWrite_Out <= 1'b0;
         Valid_Out    <= 1'b0;
         Misalign_Out <= 1'b0;
         Retired_Out  <= '0;
      end else if (Flush_In) begin
         RegWrite_Out <= 1'b0;
         Valid_Out    <= 1'b0;
         Misalign_Out <= 1'b0;
      end else if (!Stall_In) begin
         Data_Out     <= result;
         WriteReg_Out <= WriteReg_In;
         RegWrite_Out <= reg_write;
         Valid_Out    <= Valid_In;
         Misalign_Out <= Valid_In & misalign;
         if (Valid_In) Retired_Out <= Retired_Out + CNT_W'(1);
      end
   end

endmodule

// File: doc/wb_stage_p.md
Name: wb_stage_p

Overview:
Parametrised MIPS-style writeback stage that replaces the fixed 32-bit mem/ALU mux. It holds a registered MEM/WB pipeline slot with valid, stall and flush. It selects among ALU result, aligned/extended load data and link address, and drives the register-file write port. It also keeps a retired-instruction counter for the pipeline's performance debug.

Parameters:
DATA_W, 32, datapath width; a power of two, at least 32.
REG_AW, 5, register index width.
CNT_W, 32, retired counter width.
BIG_ENDIAN, 0, byte-lane order for sub-word loads (0 little, 1 big).

Ports:
Clk  input  1  clock; all state updates on posedge.
Rst_n  input  1  synchronous active-low reset.
Stall_In  input  1  hold stage contents.
Flush_In  input  1  kill the instruction entering this cycle.
Valid_In  input  1  MEM-stage instruction valid.
WBControl_In  input  6  [5:4] result select, [3:2] load size, [1] load signed, [0] RegWrite.
Address_In  input  DATA_W  ALU result / memory address.
Data_In  input  DATA_W  raw memory read word.
Link_In  input  DATA_W  return address for JAL/JALR.
WriteReg_In  input  REG_AW  destination register.
Data_Out  output  DATA_W  writeback value.
WriteReg_Out  output  REG_AW  destination register.
RegWrite_Out  output  1  register-file write enable.
Valid_Out  output  1  stage holds a live instruction.
Misalign_Out  output  1  a load was misaligned.
Retired_Out  output  CNT_W  count of retired instructions.

Behaviour:
- Reset (Rst_n=0 at posedge): all outputs and internal state become 0. Reset has priority over flush and stall.
- Latency: one cycle. Inputs are sampled at posedge N and outputs are valid after posedge N, so the register file writes on the following negedge.
- Priority: reset > flush > stall > load.
- Flush=1: Valid_Out=0, RegWrite_Out=0, Misalign_Out=0. Data_Out and WriteReg_Out hold. Flush overrides a simultaneous stall.
- Stall=1 with no flush: every output holds and the counter holds.
- Load (no stall, no flush):
  - Valid_Out <= Valid_In.
  - RegWrite_Out <= Valid_In & WBControl_In[0] & (WriteReg_In != 0) & ~misalign.
- Result select [5:4]:
  - 00: Address_In.
  - 01: aligned load.
  - 10: Link_In.
  - 11: reserved, treated as Address_In.
- Load size [3:2]:
  - 00: byte.
  - 01: half.
  - 10 or 11: full word, which is DATA_W wide.
- Byte lane: k = Address_In[log2(DATA_W/8)-1:0]. With BIG_ENDIAN=1, lane = (DATA_W/8-1-k); otherwise lane = k.
- Half lanes use the same ordering at 16-bit granularity.
- Extension: the extracted field is sign-extended when [1]=1, otherwise zero-extended, to DATA_W.
- Misalignment: set when select=01 and the address is not aligned to the access size (half: bit0; word: low log2(DATA_W/8) bits).
  - Data_Out still loads the extracted value.
  - Misalign_Out=1 for that instruction and RegWrite_Out is suppressed.
- Writes to register 0 are never enabled, whatever the control bits say.
- Retired counter: increments by 1 on each loaded cycle with Valid_In=1. It does not increment on stall, flush or reset, and wraps from 2^CNT_W-1 to 0.

Decomposition:
- Package wb_pkg holds:
  - result-select constants WB_SEL_ALU=2'b00, WB_SEL_MEM=2'b01, WB_SEL_LINK=2'b10;
  - size constants SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - the WBControl field bit positions.
- Sub-module wb_load_align: combinational; inputs raw data, address low bits, size and signed; outputs aligned data and the misalign flag. It carries DATA_W and BIG_ENDIAN.
- The top level holds the pipeline register, the result mux, the RegWrite qualification and the counter.

Test Plan:
1. Reset: drive Rst_n=0 for 2 cycles with random inputs -> every output is 0; Retired_Out=0.
2. Byte load, little endian: Data_In=32'h80FF_1234, Address_In=32'h1003, select=01, byte, signed, WriteReg=5, RegWrite=1, Valid=1 -> next cycle Data_Out=32'hFFFF_FF80, WriteReg_Out=5, RegWrite_Out=1, Retired_Out=1. The same stimulus unsigned -> 32'h0000_0080.
3. Big-endian half load (BIG_ENDIAN=1): Data_In=32'hBEEF_CAFE, Address_In=32'h2, unsigned -> 32'h0000_CAFE. Address_In=32'h3 -> Misalign_Out=1, RegWrite_Out=0.
4. JAL link: select=10, Link_In=32'h0040_0008, WriteReg=31 -> Data_Out=32'h0040_0008, RegWrite_Out=1. Same with WriteReg=0 -> RegWrite_Out=0, Valid_Out=1.
5. Stall then flush: load an ALU result 32'hA5A5 and assert Stall 3 cycles with new inputs -> outputs hold 32'hA5A5 and the counter is unchanged. Then Flush+Stall together -> Valid_Out=0, RegWrite_Out=0, Data_Out still 32'hA5A5.
6. Counter wrap (CNT_W=4): 17 valid loads -> Retired_Out=1. Interleave Valid_In=0 cycles -> no increment.
